ft245_device_emu: RTL and testbench

Synthesizable emulator of the FT245 chip side of the parallel FIFO bus. It responds to RD#/WR# strobes from an FPGA-side FT245 host master and drives RXF#/TXE# and read data. Two internal FIFOs connect the bus to a host-side ready/ack simple interface. It is used for loopback, simulation and board self-test in place of the real USB chip.

---
 rtl/ft245_device_emu_if.sv | 40 ++++
 rtl/ft245_device_emu.sv | 132 +++++++++++++
 tb/tb_ft245_device_emu.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft245_device_emu_if.sv
// Signal bundle between the FT245 device emulator, its FPGA-side bus master
// and the host-side byte stream.
interface ft245_device_emu_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data_245;
  logic          rxf_245;
  logic          rx_245;
  logic [7:0]    tx_data_245;
  logic          txe_245;
  logic          tx_245;
  logic          tx_oe_245;
  logic [7:0]    host_tx_data;
  logic          host_tx_rdy;
  logic          host_tx_ack;
  logic [7:0]    host_rx_data;
  logic          host_rx_rdy;
  logic          host_rx_ack;
  logic [LW-1:0] rx_level;
  logic [LW-1:0] tx_level;
  logic          proto_err;

  modport slave (
    output rx_data_245, rxf_245, txe_245,
    input  rx_245, tx_data_245, tx_245, tx_oe_245,
    input  host_tx_data, host_tx_rdy, host_rx_ack,
    output host_tx_ack, host_rx_data, host_rx_rdy,
    output rx_level, tx_level, proto_err
  );

  modport master (
    input  rx_data_245, rxf_245, txe_245,
    output rx_245, tx_data_245, tx_245, tx_oe_245,
    output host_tx_data, host_tx_rdy, host_rx_ack,
    input  host_tx_ack, host_rx_data, host_rx_rdy,
    input  rx_level, tx_level, proto_err
  );
endinterface

// File: rtl/ft245_device_emu.sv
// Chip-side FT245 FIFO bus emulator: answers RD#/WR# strobes from an FPGA master
// and bridges two byte FIFOs to a host-side ready/ack stream.
module ft245_device_emu #(
  parameter int DEPTH            = 16,
  parameter int RXF_INACTIVE_CYC = 5,
  parameter int TXE_INACTIVE_CYC = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ft245_device_emu_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int RHW = (RXF_INACTIVE_CYC > 0) ? $clog2(RXF_INACTIVE_CYC + 1) : 1;
  localparam int THW = (TXE_INACTIVE_CYC > 0) ? $clog2(TXE_INACTIVE_CYC + 1) : 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic           rd_q, wr_q;
  logic           rd_arm_q, wr_arm_q;
  logic           rd_fall, rd_rise, wr_fall, wr_rise;

  logic [7:0]     rx_mem_q [DEPTH];
  logic [AW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LW-1:0]  rx_level_q, rx_level_d;
  logic           rx_push, rx_pop;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rxf_q, rxf_d;
  logic [RHW-1:0] rxf_hold_q, rxf_hold_d;

  logic [7:0]     tx_mem_q [DEPTH];
  logic [AW-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [LW-1:0]  tx_level_q, tx_level_d;
  logic           tx_push, tx_pop;
  logic           txe_q, txe_d;
  logic [THW-1:0] txe_hold_q, txe_hold_d;

  logic           proto_err_q, proto_err_d;

  // A strobe held low through reset leaves its arm flag clear, so it produces
  // no edge until the master releases it and strobes again.
  always_comb begin
    rd_fall = rd_arm_q & rd_q & ~bus.rx_245;
    rd_rise = rd_arm_q & ~rd_q & bus.rx_245;
    wr_fall = wr_arm_q & wr_q & ~bus.tx_245;
    wr_rise = wr_arm_q & ~wr_q & bus.tx_245;
  end

  always_comb begin
    rx_push    = bus.host_tx_rdy & (rx_level_q != FULL);
    rx_pop     = rd_rise & (rx_level_q != '0);
    rx_wptr_d  = rx_wptr_q + AW'(rx_push);
    rx_rptr_d  = rx_rptr_q + AW'(rx_pop);
    rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);
    rx_data_d  = (!bus.rx_245 && (rx_level_q != '0)) ? rx_mem_q[rx_rptr_q] : 8'h00;
    if (rx_pop)                 rxf_hold_d = RHW'(RXF_INACTIVE_CYC);
    else if (rxf_hold_q != '0)  rxf_hold_d = rxf_hold_q - RHW'(1);
    else                        rxf_hold_d = rxf_hold_q;
    rxf_d = (rx_level_d == '0) | (rxf_hold_d != '0) | rd_rise;
  end

  always_comb begin
    tx_push    = wr_fall & ~txe_q & bus.tx_oe_245;
    tx_pop     = bus.host_rx_ack & (tx_level_q != '0);
    tx_wptr_d  = tx_wptr_q + AW'(tx_push);
    tx_rptr_d  = tx_rptr_q + AW'(tx_pop);
    tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);
    if (wr_rise)                txe_hold_d = THW'(TXE_INACTIVE_CYC);
    else if (txe_hold_q != '0)  txe_hold_d = txe_hold_q - THW'(1);
    else                        txe_hold_d = txe_hold_q;
    txe_d = ~bus.tx_245 | (txe_hold_d != '0) | (tx_level_d == FULL);
  end

  always_comb begin
    proto_err_d = proto_err_q
                | (rd_fall & rxf_q)
                | (wr_fall & (txe_q | ~bus.tx_oe_245))
                | (~bus.rx_245 & ~bus.tx_245);
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= bus.host_tx_data;
    if (tx_push) tx_mem_q[tx_wptr_q] <= bus.tx_data_245;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      rd_arm_q    <= bus.rx_245;
      wr_arm_q    <= bus.tx_245;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_level_q  <= '0;
      rx_data_q   <= 8'h00;
      rxf_q       <= 1'b1;
      rxf_hold_q  <= '0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_level_q  <= '0;
      txe_q       <= 1'b1;
      txe_hold_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_q        <= bus.rx_245;
      wr_q        <= bus.tx_245;
      rd_arm_q    <= rd_arm_q | bus.rx_245;
      wr_arm_q    <= wr_arm_q | bus.tx_245;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_level_q  <= rx_level_d;
      rx_data_q   <= rx_data_d;
      rxf_q       <= rxf_d;
      rxf_hold_q  <= rxf_hold_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_level_q  <= tx_level_d;
      txe_q       <= txe_d;
      txe_hold_q  <= txe_hold_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.rx_data_245  = rx_data_q;
  assign bus.rxf_245      = rxf_q;
  assign bus.txe_245      = txe_q;
  assign bus.host_tx_ack  = rx_push;
  assign bus.host_rx_data = tx_mem_q[tx_rptr_q];
  assign bus.host_rx_rdy  = (tx_level_q != '0);
  assign bus.rx_level     = rx_level_q;
  assign bus.tx_level     = tx_level_q;
  assign bus.proto_err    = proto_err_q;
endmodule

// File: tb/tb_ft245_device_emu.sv
// Self-checking bench for ft245_device_emu: byte scoreboards for both FIFO
// directions plus a small table of host-push vectors and hand-written corner cases.
module tb_ft245_device_emu;
  localparam int DEPTH = 16;
  localparam int HOLD  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ft245_device_emu_if #(.DEPTH(DEPTH)) bus ();

  ft245_device_emu #(
    .DEPTH(DEPTH), .RXF_INACTIVE_CYC(HOLD), .TXE_INACTIVE_CYC(HOLD)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       exp_ack;
    int         exp_level;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rxf_low();
    for (int i = 0; i < 50 && bus.rxf_245; i++) tick();
    check("rxf_ready", bus.rxf_245, 0);
  endtask

  task automatic wait_txe_low();
    for (int i = 0; i < 50 && bus.txe_245; i++) tick();
    check("txe_ready", bus.txe_245, 0);
  endtask

  task automatic host_push(input logic [7:0] b);
    bit done;
    done = 0;
    bus.host_tx_data = b;
    bus.host_tx_rdy  = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (bus.host_tx_ack) begin
        rx_q.push_back(b);
        done = 1;
      end
      tick();
    end
    bus.host_tx_rdy = 1'b0;
    if (!done) check("host_push_ack", bus.host_tx_ack, 1);
  endtask

  task automatic bus_read();
    logic [7:0] exp;
    int n;
    wait_rxf_low();
    exp = rx_q.pop_front();
    bus.rx_245 = 1'b0;
    tick();
    check("rd_data", bus.rx_data_245, exp);
    tick();
    check("rd_data_stable", bus.rx_data_245, exp);
    bus.rx_245 = 1'b1;
    tick();
    check("rx_level_after_rd", bus.rx_level, rx_q.size());
    n = 0;
    while (n < 12 && bus.rxf_245) begin
      n++;
      tick();
    end
    if (rx_q.size() != 0) check("rxf_hold_cycles", n, HOLD);
    else                  check("rxf_empty_high", n, 12);
  endtask

  task automatic bus_write(input logic [7:0] b);
    int n;
    wait_txe_low();
    bus.tx_data_245 = b;
    bus.tx_oe_245   = 1'b1;
    bus.tx_245      = 1'b0;
    tx_q.push_back(b);
    tick();
    check("txe_during_wr", bus.txe_245, 1);
    check("tx_level_after_wr", bus.tx_level, tx_q.size());
    tick();
    bus.tx_245 = 1'b1;
    tick();
    bus.tx_oe_245 = 1'b0;
    n = 0;
    while (n < 12 && bus.txe_245) begin
      n++;
      tick();
    end
    if (tx_q.size() < DEPTH) check("txe_hold_cycles", n, HOLD);
    else                     check("txe_full_high", n, 12);
  endtask

  task automatic host_pop();
    logic [7:0] exp;
    exp = tx_q.pop_front();
    check("host_rx_rdy", bus.host_rx_rdy, 1);
    check("host_rx_data", bus.host_rx_data, exp);
    bus.host_rx_ack = 1'b1;
    tick();
    bus.host_rx_ack = 1'b0;
    check("tx_level_after_pop", bus.tx_level, tx_q.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxf"},       bus.rxf_245, 1);
    check({tag, "_txe"},       bus.txe_245, 1);
    check({tag, "_rx_data"},   bus.rx_data_245, 0);
    check({tag, "_rx_level"},  bus.rx_level, 0);
    check({tag, "_tx_level"},  bus.tx_level, 0);
    check({tag, "_proto_err"}, bus.proto_err, 0);
    check({tag, "_host_rdy"},  bus.host_rx_rdy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'h00, 1'b0, 0};
    vecs[1] = '{1'b1, 8'hA5, 1'b1, 1};
    vecs[2] = '{1'b1, 8'h3C, 1'b1, 2};
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 2};

    rst_n            = 1'b0;
    bus.rx_245       = 1'b1;
    bus.tx_245       = 1'b1;
    bus.tx_oe_245    = 1'b0;
    bus.tx_data_245  = 8'h00;
    bus.host_tx_data = 8'h00;
    bus.host_tx_rdy  = 1'b0;
    bus.host_rx_ack  = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    rst_n = 1'b1;
    tick();
    check("post_reset_txe", bus.txe_245, 0);
    check("post_reset_rxf", bus.rxf_245, 1);
    check("post_reset_proto_err", bus.proto_err, 0);

    // Host-side pushes from the vector table.
    foreach (vecs[i]) begin
      bus.host_tx_rdy  = vecs[i].rdy;
      bus.host_tx_data = vecs[i].data;
      #1;
      check("tbl_ack", bus.host_tx_ack, vecs[i].exp_ack);
      if (vecs[i].exp_ack) rx_q.push_back(vecs[i].data);
      tick();
      check("tbl_rx_level", bus.rx_level, vecs[i].exp_level);
    end
    bus.host_tx_rdy = 1'b0;

    bus_read();
    bus_read();
    check("rx_level_drained", bus.rx_level, 0);

    bus_write(8'h11);
    bus_write(8'h22);
    bus_write(8'h33);
    check("tx_level_three", bus.tx_level, 3);
    check("host_head_first", bus.host_rx_data, 8'h11);
    repeat (3) host_pop();

    // Fill the TX FIFO, then strobe once more while TXE# is high.
    for (int i = 0; i < DEPTH; i++) bus_write(8'(8'h40 + i));
    check("tx_full_txe", bus.txe_245, 1);
    bus.tx_data_245 = 8'hEE;
    bus.tx_oe_245   = 1'b1;
    bus.tx_245      = 1'b0;
    tick();
    bus.tx_245    = 1'b1;
    bus.tx_oe_245 = 1'b0;
    tick();
    check("tx_overflow_level", bus.tx_level, DEPTH);
    check("tx_overflow_proto_err", bus.proto_err, 1);
    host_pop();
    for (int i = 0; i < 20 && bus.txe_245; i++) tick();
    check("txe_reopen", bus.txe_245, 0);
    while (tx_q.size() != 0) host_pop();

    // RX FIFO full with a same-cycle bus pop: the push is refused that cycle.
    for (int i = 0; i < DEPTH; i++) host_push(8'(8'h80 + i));
    check("rx_full_level", bus.rx_level, DEPTH);
    bus.host_tx_rdy  = 1'b1;
    bus.host_tx_data = 8'h77;
    #1;
    check("rx_full_ack", bus.host_tx_ack, 0);
    wait_rxf_low();
    bus.rx_245 = 1'b0;
    tick();
    check("rx_full_rd_data", bus.rx_data_245, rx_q[0]);
    void'(rx_q.pop_front());
    bus.rx_245 = 1'b1;
    #1;
    check("rx_full_same_cycle_ack", bus.host_tx_ack, 0);
    tick();
    check("rx_full_next_ack", bus.host_tx_ack, 1);
    rx_q.push_back(8'h77);
    tick();
    bus.host_tx_rdy = 1'b0;
    check("rx_refill_level", bus.rx_level, DEPTH);
    while (rx_q.size() != 0) bus_read();

    // Streaming through pointer wrap.
    for (int i = 0; i < 40; i++) begin
      host_push(8'(i * 3 + 1));
      if (rx_q.size() >= 3) bus_read();
    end
    while (rx_q.size() != 0) bus_read();
    check("stream_rx_level", bus.rx_level, 0);

    // Reset in the middle of a write burst with WR# held low through reset.
    host_push(8'hA1);
    host_push(8'hB2);
    bus_write(8'h55);
    bus_write(8'h66);
    bus.tx_data_245 = 8'h99;
    bus.tx_oe_245   = 1'b1;
    bus.tx_245      = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rx_q.delete();
    tx_q.delete();
    rst_n = 1'b1;
    tick();
    check("held_wr_txe", bus.txe_245, 1);
    tick();
    bus.tx_245    = 1'b1;
    bus.tx_oe_245 = 1'b0;
    tick();
    tick();
    check("held_wr_no_push", bus.tx_level, 0);
    check("held_wr_no_proto_err", bus.proto_err, 0);
    check("held_wr_txe_open", bus.txe_245, 0);

    // RD# pulse on an empty FIFO.
    bus.rx_245 = 1'b0;
    tick();
    check("empty_rd_data", bus.rx_data_245, 0);
    bus.rx_245 = 1'b1;
    tick();
    check("empty_rd_proto_err", bus.proto_err, 1);
    check("empty_rd_level", bus.rx_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
